comp_arbiter: RTL and testbench

- Round-robin scheduler that shares one `comp8` 8-bit comparator instance among NUM_REQ requesters.
- Each requester uses a valid/ready handshake to submit an operand pair, then receives a 3-bit GT/LT/EQ result through a response handshake.
- Sits between multiple ALU-side clients and the single comparator datapath; only one comparison is in flight at a time.

---
 rtl/comp_arb_pkg.sv | 16 +
 rtl/comp8.sv | 10 +
 rtl/comp_rr_arbiter.sv | 31 +++
 rtl/comp_arbiter.sv | 109 ++++++++++
 tb/tb_comp_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/comp_arb_pkg.sv
// Shared types and constants for the round-robin comparator arbiter.
package comp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int FLAG_GT = 0;
    localparam int FLAG_LT = 1;
    localparam int FLAG_EQ = 2;

    localparam int STATS_W = 16;

endpackage

// File: rtl/comp8.sv
// Existing 8-bit magnitude comparator: Cout = {A==B, A<B, A>B}.
module comp8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [2:0] Cout
);

    assign Cout = {(A == B), (A < B), (A > B)};

endmodule

// File: rtl/comp_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above rr_ptr, wrapping.
module comp_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[PTR_W'(idx)]) begin
                found                = 1'b1;
                grant[PTR_W'(idx)]   = 1'b1;
                grant_idx            = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/comp_arbiter.sv
// Round-robin scheduler sharing one comp8 among NUM_REQ requesters.
// Define COMP_ARB_STATS_EN to add saturating cmp_count/eq_count outputs.
module comp_arbiter
    import comp_arb_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [NUM_REQ-1:0]   resp_valid,
    output logic [2:0]           resp_flags,
    input  logic [NUM_REQ-1:0]   resp_ready,
    output logic                 busy
`ifdef COMP_ARB_STATS_EN
    ,
    output logic [STATS_W-1:0]   cmp_count,
    output logic [STATS_W-1:0]   eq_count
`endif
);

    state_t               state_q;
    logic [PTR_W-1:0]     rr_ptr_q;
    logic [PTR_W-1:0]     grant_id_q;
    logic [7:0]           op_a_q, op_b_q;
    logic [2:0]           flags_q;
    logic [NUM_REQ-1:0]   resp_valid_q;
    logic [NUM_REQ-1:0]   grant;
    logic [PTR_W-1:0]     grant_idx;
    logic [2:0]           cout;
`ifdef COMP_ARB_STATS_EN
    logic [STATS_W-1:0]   cmp_count_q, eq_count_q;
`endif

    comp_rr_arbiter #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_rr (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    comp8 u_comp8 (
        .A    (op_a_q),
        .B    (op_b_q),
        .Cout (cout)
    );

    // Grant is only offered from IDLE and forced low while reset is asserted.
    assign req_ready  = (state_q == IDLE && rst_n) ? grant : '0;
    assign resp_valid = resp_valid_q;
    assign resp_flags = flags_q;
    assign busy       = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_id_q   <= '0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            flags_q      <= '0;
            resp_valid_q <= '0;
`ifdef COMP_ARB_STATS_EN
            cmp_count_q  <= '0;
            eq_count_q   <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        op_a_q     <= req_a[{grant_idx, 3'b000} +: 8];
                        op_b_q     <= req_b[{grant_idx, 3'b000} +: 8];
                        grant_id_q <= grant_idx;
                        state_q    <= EVAL;
                    end
                end
                EVAL: begin
                    flags_q                  <= cout;
                    resp_valid_q             <= '0;
                    resp_valid_q[grant_id_q] <= 1'b1;
                    state_q                  <= RESP;
                end
                RESP: begin
                    if (resp_ready[grant_id_q]) begin
                        resp_valid_q <= '0;
                        rr_ptr_q     <= (grant_id_q == PTR_W'(NUM_REQ - 1)) ? '0
                                                                            : grant_id_q + 1'b1;
                        state_q      <= IDLE;
`ifdef COMP_ARB_STATS_EN
                        if (cmp_count_q != '1) cmp_count_q <= cmp_count_q + 1'b1;
                        if (flags_q[FLAG_EQ] && eq_count_q != '1) eq_count_q <= eq_count_q + 1'b1;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef COMP_ARB_STATS_EN
    assign cmp_count = cmp_count_q;
    assign eq_count  = eq_count_q;
`endif

endmodule

// File: tb/tb_comp_arbiter.sv
// Directed self-checking bench for comp_arbiter (NUM_REQ=4); stats checks under COMP_ARB_STATS_EN.
module tb_comp_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_ready;
    logic [3:0]  resp_valid;
    logic [2:0]  resp_flags;
    logic [3:0]  resp_ready;
    logic        busy;
`ifdef COMP_ARB_STATS_EN
    logic [15:0] cmp_count, eq_count;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    comp_arbiter #(.NUM_REQ(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_flags (resp_flags),
        .resp_ready (resp_ready),
        .busy       (busy)
`ifdef COMP_ARB_STATS_EN
        ,
        .cmp_count  (cmp_count),
        .eq_count   (eq_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n      = 1'b0;
        req_valid  = '0;
        resp_ready = '1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One full transaction from requester idx, checking grant, latency and flags.
    task automatic do_cmp(input int idx, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] expf, input string tag);
        logic [3:0] oh;
        oh = '0;
        oh[idx] = 1'b1;
        @(negedge clk);
        req_a[idx*8 +: 8] = a;
        req_b[idx*8 +: 8] = b;
        req_valid = oh;
        #1 chk({tag, "_ready"}, 16'(req_ready), 16'(oh));
        @(negedge clk);
        req_valid = '0;
        #1 chk({tag, "_eval_busy"}, 16'(busy), 16'd1);
        chk({tag, "_eval_nordy"}, 16'(req_ready), 16'd0);
        chk({tag, "_eval_novld"}, 16'(resp_valid), 16'd0);
        @(negedge clk);
        #1 chk({tag, "_rvalid"}, 16'(resp_valid), 16'(oh));
        chk({tag, "_flags"}, 16'(resp_flags), 16'(expf));
        @(negedge clk);
        #1 chk({tag, "_idle_busy"}, 16'(busy), 16'd0);
        chk({tag, "_idle_rvalid"}, 16'(resp_valid), 16'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", 16'(req_ready), 16'd0);
        chk("rst_rvalid", 16'(resp_valid), 16'd0);
        chk("rst_flags", 16'(resp_flags), 16'd0);
        chk("rst_busy", 16'(busy), 16'd0);
        rst_n = 1'b1;

        // Single request, then equal and less-than on requester 1.
        do_cmp(0, 8'h5A, 8'h3C, 3'b001, "gt0");
        do_cmp(1, 8'h80, 8'h80, 3'b100, "eq1");
        do_cmp(1, 8'h00, 8'hFF, 3'b010, "lt1");

        // Round-robin with all requesters valid from reset.
        do_reset();
        req_valid = 4'hF;
        req_a = 32'h40302010;
        req_b = 32'h40302010;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] oh;
            oh = '0;
            oh[k % 4] = 1'b1;
            #1 chk($sformatf("rr_grant%0d", k), 16'(req_ready), 16'(oh));
            @(negedge clk);
            #1 chk($sformatf("rr_eval_nordy%0d", k), 16'(req_ready), 16'd0);
            @(negedge clk);
            #1 chk($sformatf("rr_rvalid%0d", k), 16'(resp_valid), 16'(oh));
            chk($sformatf("rr_flags%0d", k), 16'(resp_flags), 16'b100);
            @(negedge clk);
        end
        req_valid = '0;

        // Backpressure on requester 2 while requester 0 waits.
        do_reset();
        req_a[23:16] = 8'h10;
        req_b[23:16] = 8'h20;
        req_valid    = 4'b0100;
        resp_ready   = 4'b1011;
        #1 chk("bp_grant2", 16'(req_ready), 16'b0100);
        @(negedge clk);
        req_valid = 4'b0001;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1 chk($sformatf("bp_rvalid%0d", k), 16'(resp_valid), 16'b0100);
            chk($sformatf("bp_flags%0d", k), 16'(resp_flags), 16'b010);
            chk($sformatf("bp_nordy%0d", k), 16'(req_ready), 16'd0);
            @(negedge clk);
        end
        resp_ready = 4'b1111;
        @(negedge clk);
        #1 chk("bp_grant0", 16'(req_ready), 16'b0001);
        chk("bp_released", 16'(resp_valid), 16'd0);
        @(negedge clk);
        req_valid = '0;
        repeat (3) @(negedge clk);

        // Reset in the middle of EVAL aborts the comparison.
        req_a[31:24] = 8'h01;
        req_b[31:24] = 8'h02;
        req_valid    = 4'b1000;
        #1 chk("abort_grant3", 16'(req_ready), 16'b1000);
        @(negedge clk);
        #1 chk("abort_eval_busy", 16'(busy), 16'd1);
        rst_n     = 1'b0;
        req_valid = '0;
        #1 chk("abort_rvalid", 16'(resp_valid), 16'd0);
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_ready", 16'(req_ready), 16'd0);
        chk("abort_flags", 16'(resp_flags), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1 chk($sformatf("abort_norsp%0d", k), 16'(resp_valid), 16'd0);
        end

`ifdef COMP_ARB_STATS_EN
        do_reset();
        #1 chk("st_rst_cmp", cmp_count, 16'd0);
        do_cmp(0, 8'h11, 8'h22, 3'b010, "st_a");
        do_cmp(1, 8'h33, 8'h33, 3'b100, "st_b");
        do_cmp(2, 8'h99, 8'h01, 3'b001, "st_c");
        chk("st_cmp3", cmp_count, 16'd3);
        chk("st_eq1", eq_count, 16'd1);
        force dut.cmp_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.cmp_count_q;
        do_cmp(3, 8'h05, 8'h05, 3'b100, "st_d");
        chk("st_cmp_sat", cmp_count, 16'hFFFF);
        chk("st_eq2", eq_count, 16'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
